idct4_stream_ctrl: RTL
======================

Name: idct4_stream_ctrl

Overview:
- Input-side sequencer and output tracker for the 4-point 2D IDCT pipeline (row stages 1-4 feeding column stages 5-8 through the mod-4 rotation counter).
- Accepts 4-coefficient rows over a valid/ready stream and groups them into 4-row blocks.
- Launches each block so that row 0 reaches the core exactly when the core's free-running counter is at phase 0.
- Zero-fills bubbles, and tags core output rows with valid/row-index/last after a fixed pipeline latency.

Parameters:
- DW, 25, width of one signed coefficient.
- LATENCY, 12, cycles from a row on core_din to its transformed row on the core outputs (legal range 1..64).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset (see Behaviour).
- in_valid  in  1  input row valid.
- in_ready  out  1  controller can accept a row this cycle.
- in_data  in  4*DW  row {c3,c2,c1,c0}, c0 in LSBs, signed.
- flush  in  1  synchronous abort, single-cycle pulse.
- err_clr  in  1  clears underrun_err.
- core_din  out  4*DW  row driven to the core's d_in_1..d_in_4, registered.
- core_phase  out  2  mirror of the core rotation counter.
- out_valid  out  1  core output row this cycle belongs to a block.
- out_row  out  2  index 0..3 of that row within its block.
- out_block_last  out  1  out_valid and out_row==3.
- busy  out  1  block being launched or rows in flight.
- underrun_err  out  1  sticky: a row was missing mid-block.
- block_cnt  out  CNT_W  completed blocks, wraps.

Behaviour:
- Reset:
  - Asynchronous, active-high on reset; clock clk, rising edge.
  - All state clears: phase=0, state=IDLE, row_idx=0, tracker empty, core_din=0, out_valid=0, out_row=0, out_block_last=0, busy=0, underrun_err=0, block_cnt=0.
  - Reset mid-block discards the block with no partial output.
- Phase counter: core_phase increments every cycle, 3->0 wrap. It is never stalled or reset by flush, so it stays locked to the core counter.
- Acceptance: a row is accepted when in_valid&&in_ready at cycle t. It appears on core_din at t+1. core_din=0 in any cycle with no accepted row.
- State IDLE:
  - in_ready = (core_phase==3).
  - Accepting at phase 3 puts row 0 on core_din at phase 0. Set row_idx=1 and go to RUN.
- State RUN:
  - in_ready=1. Each cycle emits exactly one row slot for row_idx.
  - If in_valid=1, the row is accepted.
  - If in_valid=0, a zero row is inserted for that slot and underrun_err is set.
  - row_idx increments each cycle. After slot 3, return to IDLE.
  - RUN always lasts exactly 3 cycles, at phases 0,1,2.
- Back-to-back blocks: the next IDLE cycle is at phase 3, so the next block starts with no gap. Sustained throughput is 4 rows per 4 cycles.
- Tracker:
  - LATENCY-deep shift register of {valid,row,last}, loaded in the same cycle core_din is loaded.
  - out_valid/out_row/out_block_last assert exactly LATENCY cycles after the row was on core_din.
  - Zero-filled underrun rows are tracked as valid.
  - Idle bubbles are tracked as invalid.
- block_cnt: increments on out_block_last, wraps 2^CNT_W-1 -> 0.
- busy = (state==RUN) || any tracker stage valid.
- flush:
  - Returns state to IDLE, sets row_idx=0, clears the tracker, and forces core_din=0 next cycle.
  - in_ready=0 during the flush cycle.
  - underrun_err and block_cnt are unaffected.
  - flush together with acceptance: flush wins and the row is dropped.
- underrun_err: a set and err_clr in the same cycle leaves the flag set (set wins).
- Arithmetic: pass-through only. No width change or saturation on data.

Test Plan:
- Reset released, in_valid held 1 from cycle 0 -> in_ready first high at phase 3 (cycle 3). Rows 0..3 appear on core_din in cycles 4..7.
- Same stimulus, LATENCY=12 -> out_valid high in cycles 16..19 with out_row 0,1,2,3. out_block_last in cycle 19. block_cnt=1 in cycle 20.
- 3 blocks back-to-back with rows valued 1..12 -> core_din carries 1..12 in 12 consecutive cycles with no zero gap. block_cnt reaches 3 and busy drops LATENCY cycles after the last row.
- in_valid dropped for the row-2 slot -> core_din=0 in that slot, underrun_err=1, out_valid still high for all 4 rows. err_clr pulsed in the same cycle as the set -> flag stays 1; err_clr in a later cycle -> 0.
- flush during the row-1 slot -> core_din=0 from the next cycle, no out_valid for that block, and the next block launches at the next phase 3.
- Async reset mid-block (row 2) -> all outputs 0 immediately. core_phase restarts at 0 and block_cnt=0.

Source files
------------

// File: rtl/idct4_stream_ctrl.sv
// Input sequencer and output tracker for the 4-point 2D IDCT core: launches 4-row
// blocks phase-aligned to the core rotation counter and tags core output rows.
module idct4_stream_ctrl #(
    parameter int DW      = 25,
    parameter int LATENCY = 12,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4*DW-1:0]   in_data_i,
    input  logic              flush_i,
    input  logic              err_clr_i,
    output logic [4*DW-1:0]   core_din_o,
    output logic [1:0]        core_phase_o,
    output logic              out_valid_o,
    output logic [1:0]        out_row_o,
    output logic              out_block_last_o,
    output logic              busy_o,
    output logic              underrun_err_o,
    output logic [CNT_W-1:0]  block_cnt_o
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] row;
        logic       last;
    } trk_t;

    state_t              state_q;
    logic [1:0]          phase_q;
    logic [1:0]          row_idx_q;
    logic [4*DW-1:0]     din_q;
    trk_t [LATENCY:0]    trk_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                underrun;
    trk_t                trk_d;
    trk_t                trk_out;

    // A block may only start at phase 3 so its row 0 hits the core at phase 0.
    assign in_ready_o = !flush_i && ((state_q == RUN) || (phase_q == 2'd3));
    assign accept     = in_valid_i && in_ready_o;
    assign underrun   = (state_q == RUN) && !flush_i && !in_valid_i;
    assign trk_out    = trk_q[LATENCY];

    always_comb begin
        trk_d = '0;
        if (!flush_i) begin
            if (state_q == RUN) begin
                trk_d.valid = 1'b1;
                trk_d.row   = row_idx_q;
                trk_d.last  = (row_idx_q == 2'd3);
            end else if (accept) begin
                trk_d.valid = 1'b1;
            end
        end
    end

    always_comb begin
        busy_o = (state_q == RUN);
        for (int i = 0; i <= LATENCY; i++)
            busy_o = busy_o | trk_q[i].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            row_idx_q <= 2'd0;
            din_q     <= '0;
            trk_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            phase_q <= phase_q + 2'd1;
            // Missing RUN rows and bubbles both fall through to a zero row here.
            din_q   <= accept ? in_data_i : '0;

            trk_q[0] <= trk_d;
            for (int i = 1; i <= LATENCY; i++)
                trk_q[i] <= trk_q[i-1];
            if (flush_i)
                trk_q <= '0;

            if (flush_i) begin
                state_q   <= IDLE;
                row_idx_q <= 2'd0;
            end else begin
                case (state_q)
                    IDLE: if (accept) begin
                        state_q   <= RUN;
                        row_idx_q <= 2'd1;
                    end
                    RUN: begin
                        row_idx_q <= row_idx_q + 2'd1;
                        if (row_idx_q == 2'd3)
                            state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (underrun)
                err_q <= 1'b1;
            else if (err_clr_i)
                err_q <= 1'b0;

            if (trk_out.valid && trk_out.last)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign core_din_o       = din_q;
    assign core_phase_o     = phase_q;
    assign out_valid_o      = trk_out.valid;
    assign out_row_o        = trk_out.row;
    assign out_block_last_o = trk_out.valid && trk_out.last;
    assign underrun_err_o   = err_q;
    assign block_cnt_o      = cnt_q;

endmodule
